cam_config_seq: RTL and testbench
=================================

// Module: cam_config_seq
// PURPOSE
//  Parametrised successor to the camera config sequencer. Walks a register ROM of
//  {reg,data} entries, issues one I2C/SCCB write per entry, honours delay and end
//  markers, retries NACKed writes, flags errors. Sits between cam_rom and the I2C master.
// PARAMETERS
//  CLK_F        27_000_000  input clock Hz; ms tick = CLK_F/1000 cycles
//  CAM_I2C_ADDR 8'h42       7-bit addr + W bit driven on o_i2c_addr
//  REG_W        8           register-address field width (8 or 16)
//  ROM_AW       8           ROM address width; last entry index 2**ROM_AW-1
//  ROM_LAT      1           ROM read latency, cycles (1..3)
//  DELAY_MS     10          wait per delay marker, ms
//  MAX_RETRY    3           re-sends after NACK before error (0 = none)
//  BUSY_TO      1024        cycles allowed for ready to drop after start
// PORTS
//  i_clk           in   1          system clock
//  i_rstn          in   1          async active-low reset
//  i_config_start  in   1          pulse: start/restart sequence from addr 0
//  i_i2c_ready     in   1          I2C master idle
//  i_i2c_nack      in   1          valid on cycle ready returns high: 1 = NACK
//  i_rom_data      in   REG_W+8    {reg, data}
//  o_rom_addr      out  ROM_AW     current ROM index
//  o_i2c_start     out  1          one-cycle write request
//  o_i2c_addr      out  8          = CAM_I2C_ADDR
//  o_i2c_reg       out  REG_W      register address, held through transfer
//  o_i2c_data      out  8          register data, held through transfer
//  o_busy          out  1          sequence running
//  o_config_done   out  1          sticky: sequence finished without error
//  o_config_err    out  1          sticky: retries exhausted, ready timeout or no end marker
//  o_err_addr      out  ROM_AW     ROM index of failing entry
// BEHAVIOUR
//  Reset: all outputs 0 except o_i2c_addr=CAM_I2C_ADDR; state IDLE.
//  Markers (reg field all ones): data 8'hFF = END, 8'hF0 = DELAY; other data = normal write.
//  States:
//   IDLE: on i_config_start: addr<=0, clear done/err, busy<=1 -> ROM_RD.
//   ROM_RD: wait ROM_LAT cycles after addr settles -> DECODE.
//   DECODE: END -> DONE; DELAY -> DLY; else latch reg/data, retry cnt<=0 -> SEND.
//   SEND: when i_i2c_ready=1 assert o_i2c_start exactly 1 cycle -> WAIT_BUSY.
//   WAIT_BUSY: ready=0 -> WAIT_DONE; BUSY_TO cycles with ready=1 -> ERR.
//   WAIT_DONE: ready 0->1 edge: nack=0 -> NEXT; nack=1 and retry<MAX_RETRY ->
//     retry++ -> SEND; else -> ERR.
//   DLY: count DELAY_MS*(CLK_F/1000) cycles -> NEXT.
//   NEXT: addr==2**ROM_AW-1 with no END -> ERR; else addr++ -> ROM_RD.
//   DONE: busy<=0, done<=1 -> IDLE.  ERR: busy<=0, err<=1, err_addr<=addr -> IDLE.
//  Latency: start pulse to first o_i2c_start = ROM_LAT+3 cycles if ready high.
//  i_config_start while busy: ignored unless state is DLY or ERR-free IDLE; during an
//   I2C transfer the restart is latched and taken after WAIT_DONE (never abort a bus
//   transaction). Restart clears done/err.
//  Never assert o_i2c_start while ready=0. Async reset mid-transfer: all to reset values.
//  Delay counter width = clog2(DELAY_MS*CLK_F/1000+1); no overflow at max params.
// STRUCTURE
//  cam_cfg_pkg: state enum encoding, END_DATA=8'hFF, DELAY_DATA=8'hF0, marker-decode
//   function parametrised by REG_W.
//  Sub-module cam_cfg_delay_timer: load/count/expire ms timer (CLK_F, DELAY_MS).
// TESTING (CLK_F=1_000_000, ROM_LAT=1, model ROM + I2C responder)
//  ROM {0x12_80, FF_F0, 0x11_01, FF_FF}: 2 starts, data 80 then 01, 10_000-cycle gap,
//   done=1, err=0, busy=0.
//  NACK first 2 tries of 0x3A_04, MAX_RETRY=3: 3 starts same reg/data, done=1.
//  NACK 4 times, MAX_RETRY=3: 4 starts, err=1, err_addr=entry index, done=0.
//  Ready never drops after start: err=1 after BUSY_TO cycles.
//  REG_W=16, entry 0x300A_56 then FFFF_FF: o_i2c_reg=16'h300A, done=1.
//  Restart pulse during WAIT_DONE and async reset mid-DLY: no extra start pulse before
//   transfer ends; after reset all outputs at reset values, sequence reruns from addr 0.

Source files
------------

// File: rtl/cam_cfg_pkg.sv
// Shared state encoding, marker codes and marker decode for the camera
// configuration sequencer.
package cam_cfg_pkg;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ROM_RD    = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_SEND      = 4'd3;
  localparam logic [3:0] S_WAIT_BUSY = 4'd4;
  localparam logic [3:0] S_WAIT_DONE = 4'd5;
  localparam logic [3:0] S_DLY       = 4'd6;
  localparam logic [3:0] S_NEXT      = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;
  localparam logic [3:0] S_ERR       = 4'd9;

  localparam logic [7:0] END_DATA   = 8'hFF;
  localparam logic [7:0] DELAY_DATA = 8'hF0;

  typedef enum logic [1:0] { MK_WRITE, MK_END, MK_DELAY } marker_e;

  // A marker is an entry whose register field (reg_w bits wide) is all ones.
  function automatic marker_e decode_marker(input logic [15:0] reg_f, input int reg_w,
                                            input logic [7:0] data_f);
    logic ones;
    ones = 1'b1;
    for (int i = 0; i < 16; i++)
      if (i < reg_w && !reg_f[i]) ones = 1'b0;
    if (!ones) return MK_WRITE;
    if (data_f == END_DATA) return MK_END;
    if (data_f == DELAY_DATA) return MK_DELAY;
    return MK_WRITE;
  endfunction

endpackage

// File: rtl/cam_cfg_delay_timer.sv
// Millisecond delay timer: load arms it, it counts down while enabled and
// reports expiry once DELAY_MS worth of clock cycles have elapsed.
module cam_cfg_delay_timer #(
  parameter int CLK_F    = 27_000_000,
  parameter int DELAY_MS = 10
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);
  localparam longint TICKS = longint'(DELAY_MS) * longint'(CLK_F / 1000);
  localparam int     CW    = (TICKS < 1) ? 1 : $clog2(TICKS + 1);
  // Loaded with TICKS-1 so expiry lands on the last counted cycle.
  localparam logic [CW-1:0] LOAD_V = (TICKS < 1) ? '0 : CW'(TICKS - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                   cnt_q <= '0;
    else if (i_load)               cnt_q <= LOAD_V;
    else if (i_en && cnt_q != '0)  cnt_q <= cnt_q - CW'(1);
  end

  assign o_expired = (cnt_q == '0);

endmodule

// File: rtl/cam_config_seq.sv
// Camera configuration sequencer: walks a {reg,data} ROM, issues one I2C write
// per entry, honours END/DELAY markers, retries NACKs and flags errors.
module cam_config_seq
  import cam_cfg_pkg::*;
#(
  parameter int         CLK_F        = 27_000_000,
  parameter logic [7:0] CAM_I2C_ADDR = 8'h42,
  parameter int         REG_W        = 8,
  parameter int         ROM_AW       = 8,
  parameter int         ROM_LAT      = 1,
  parameter int         DELAY_MS     = 10,
  parameter int         MAX_RETRY    = 3,
  parameter int         BUSY_TO      = 1024
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_config_start,
  input  logic              i_i2c_ready,
  input  logic              i_i2c_nack,
  input  logic [REG_W+7:0]  i_rom_data,
  output logic [ROM_AW-1:0] o_rom_addr,
  output logic              o_i2c_start,
  output logic [7:0]        o_i2c_addr,
  output logic [REG_W-1:0]  o_i2c_reg,
  output logic [7:0]        o_i2c_data,
  output logic              o_busy,
  output logic              o_config_done,
  output logic              o_config_err,
  output logic [ROM_AW-1:0] o_err_addr
);
  localparam int RW  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int BTW = $clog2(BUSY_TO + 1);
  localparam logic [1:0]     LAT_LAST = 2'(ROM_LAT - 1);
  localparam logic [BTW-1:0] BTO_LAST = BTW'(BUSY_TO - 1);

  logic [3:0]        state_q, state_d;
  logic [ROM_AW-1:0] addr_q, addr_d, eaddr_q, eaddr_d;
  logic [1:0]        lat_q, lat_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [BTW-1:0]    bto_q, bto_d;
  logic [REG_W-1:0]  reg_q, reg_d;
  logic [7:0]        data_q, data_d;
  logic              start_q, start_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              pend_q, pend_d, go, tmr_exp;
  marker_e           mk;

  assign mk = decode_marker(16'(i_rom_data[REG_W+7:8]), REG_W, i_rom_data[7:0]);

  cam_cfg_delay_timer #(.CLK_F(CLK_F), .DELAY_MS(DELAY_MS)) u_dly (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_load   (state_q == S_DECODE && mk == MK_DELAY),
    .i_en     (state_q == S_DLY),
    .o_expired(tmr_exp)
  );

  always_comb begin
    state_d = state_q;  addr_d  = addr_q;  eaddr_d = eaddr_q; lat_d  = lat_q;
    retry_d = retry_q;  bto_d   = bto_q;   reg_d   = reg_q;   data_d = data_q;
    busy_d  = busy_q;   done_d  = done_q;  err_d   = err_q;   pend_d = pend_q;
    start_d = 1'b0;
    go      = 1'b0;
    case (state_q)
      S_IDLE:   go = i_config_start;
      S_ROM_RD: if (lat_q == LAT_LAST) state_d = S_DECODE;
                else lat_d = lat_q + 2'd1;
      S_DECODE: begin
        case (mk)
          MK_END:   state_d = S_DONE;
          MK_DELAY: state_d = S_DLY;
          default: begin
            reg_d   = i_rom_data[REG_W+7:8];
            data_d  = i_rom_data[7:0];
            retry_d = '0;
            state_d = S_SEND;
          end
        endcase
      end
      S_SEND: if (i_i2c_ready) begin
        start_d = 1'b1;
        bto_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      // A restart during a bus transaction is held until the transfer completes.
      S_WAIT_BUSY: begin
        if (i_config_start) pend_d = 1'b1;
        if (!i_i2c_ready)           state_d = S_WAIT_DONE;
        else if (bto_q == BTO_LAST) state_d = S_ERR;
        else                        bto_d = bto_q + BTW'(1);
      end
      S_WAIT_DONE: begin
        if (i_config_start) pend_d = 1'b1;
        if (i_i2c_ready) begin
          if (pend_q || i_config_start)       go = 1'b1;
          else if (!i_i2c_nack)               state_d = S_NEXT;
          else if (int'(retry_q) < MAX_RETRY) begin
            retry_d = retry_q + RW'(1);
            state_d = S_SEND;
          end
          else                                state_d = S_ERR;
        end
      end
      S_DLY: if (i_config_start) go = 1'b1;
             else if (tmr_exp)   state_d = S_NEXT;
      S_NEXT: begin
        if (addr_q == '1) state_d = S_ERR;
        else begin
          addr_d  = addr_q + ROM_AW'(1);
          lat_d   = '0;
          state_d = S_ROM_RD;
        end
      end
      S_DONE: begin
        busy_d = 1'b0; done_d = 1'b1; pend_d = 1'b0; state_d = S_IDLE;
      end
      S_ERR: begin
        busy_d = 1'b0; err_d = 1'b1; eaddr_d = addr_q; pend_d = 1'b0; state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (go) begin
      addr_d = '0; lat_d = '0; done_d = 1'b0; err_d = 1'b0;
      busy_d = 1'b1; pend_d = 1'b0; state_d = S_ROM_RD;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE; addr_q <= '0; eaddr_q <= '0; lat_q <= '0; retry_q <= '0;
      bto_q   <= '0;     reg_q  <= '0; data_q  <= '0; start_q <= 1'b0; busy_q <= 1'b0;
      done_q  <= 1'b0;   err_q  <= 1'b0; pend_q <= 1'b0;
    end else begin
      state_q <= state_d; addr_q <= addr_d; eaddr_q <= eaddr_d; lat_q <= lat_d;
      retry_q <= retry_d; bto_q  <= bto_d;  reg_q   <= reg_d;   data_q <= data_d;
      start_q <= start_d; busy_q <= busy_d; done_q  <= done_d;  err_q  <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign o_rom_addr    = addr_q;
  assign o_i2c_start   = start_q;
  assign o_i2c_addr    = CAM_I2C_ADDR;
  assign o_i2c_reg     = reg_q;
  assign o_i2c_data    = data_q;
  assign o_busy        = busy_q;
  assign o_config_done = done_q;
  assign o_config_err  = err_q;
  assign o_err_addr    = eaddr_q;

endmodule

// File: tb/tb_cam_config_seq.sv
// Bench for cam_config_seq: ROM + I2C responder models, a transaction-level
// reference of the expected write sequence, and a per-cycle output checker.
module tb_cam_config_seq;
  localparam int NE = 16, MAXR = 3, BTO = 1024, DLYC = 10_000;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A: 8-bit registers ----------------
  logic        cfg_start = 1'b0, rdy = 1'b1, nack = 1'b0;
  logic [15:0] rom_a [NE];
  logic [15:0] rom_q = '0;
  logic [3:0]  rom_addr, err_addr;
  logic        o_start, o_busy, o_done, o_err;
  logic [7:0]  o_addr, o_reg, o_data;

  cam_config_seq #(.CLK_F(1_000_000), .CAM_I2C_ADDR(8'h42), .REG_W(8), .ROM_AW(4),
                   .ROM_LAT(1), .DELAY_MS(10), .MAX_RETRY(MAXR), .BUSY_TO(BTO)) dut (
    .i_clk(clk), .i_rstn(rst_n), .i_config_start(cfg_start), .i_i2c_ready(rdy),
    .i_i2c_nack(nack), .i_rom_data(rom_q), .o_rom_addr(rom_addr), .o_i2c_start(o_start),
    .o_i2c_addr(o_addr), .o_i2c_reg(o_reg), .o_i2c_data(o_data), .o_busy(o_busy),
    .o_config_done(o_done), .o_config_err(o_err), .o_err_addr(err_addr));

  always @(posedge clk) rom_q <= rom_a[rom_addr];

  // ---------------- DUT B: 16-bit registers ----------------
  logic        cfg_start_b = 1'b0, rdy_b = 1'b1, nack_b = 1'b0;
  logic [23:0] rom_b [4];
  logic [23:0] rom_qb = '0;
  logic [1:0]  rom_addr_b, err_addr_b;
  logic        ob_start, ob_busy, ob_done, ob_err;
  logic [7:0]  ob_addr, ob_data;
  logic [15:0] ob_reg;

  cam_config_seq #(.CLK_F(1_000_000), .CAM_I2C_ADDR(8'h42), .REG_W(16), .ROM_AW(2),
                   .ROM_LAT(1), .DELAY_MS(10), .MAX_RETRY(MAXR), .BUSY_TO(BTO)) dut_b (
    .i_clk(clk), .i_rstn(rst_n), .i_config_start(cfg_start_b), .i_i2c_ready(rdy_b),
    .i_i2c_nack(nack_b), .i_rom_data(rom_qb), .o_rom_addr(rom_addr_b), .o_i2c_start(ob_start),
    .o_i2c_addr(ob_addr), .o_i2c_reg(ob_reg), .o_i2c_data(ob_data), .o_busy(ob_busy),
    .o_config_done(ob_done), .o_config_err(ob_err), .o_err_addr(err_addr_b));

  always @(posedge clk) rom_qb <= rom_b[rom_addr_b];

  // ---------------- I2C responders (driven on the falling edge) ----------------
  logic [15:0] log_q[$];
  int          log_cyc[$];
  logic [15:0] cur_w = '0;
  int resp_cnt = 0, resp_min = 1, resp_max = 5, nack_left = 0, nack_from = 0, n_starts = 0;
  bit stuck = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rdy = 1'b1; nack = 1'b0; resp_cnt = 0;
    end else if (o_start) begin
      log_q.push_back({o_reg, o_data});
      log_cyc.push_back(cyc);
      cur_w = {o_reg, o_data};
      if (!stuck) begin
        rdy      = 1'b0;
        resp_cnt = $urandom_range(resp_max, resp_min);
        nack     = (n_starts >= nack_from) && (nack_left > 0);
        if (nack) nack_left--;
      end
      n_starts++;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) rdy = 1'b1;
    end
  end

  logic [23:0] log_b = '0;
  int rb_cnt = 0, nb = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      rdy_b = 1'b1; rb_cnt = 0;
    end else if (ob_start) begin
      log_b = {ob_reg, ob_data}; nb++; rdy_b = 1'b0; rb_cnt = 3;
    end else if (rb_cnt > 0) begin
      rb_cnt--;
      if (rb_cnt == 0) rdy_b = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle invariants, sampled just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("i2c_addr", o_addr, 8'h42);
      if (o_start) chk("start_needs_ready", rdy, 1'b1);
      if (resp_cnt > 0) begin
        chk("xfer_hold", {o_reg, o_data}, cur_w);
        chk("busy_in_xfer", o_busy, 1'b1);
      end
      if (o_done) chk("done_excl_err", o_err, 1'b0);
    end
  end

  // ---------------- reference model: expected writes and final flags ----------------
  logic [15:0] exp_q[$];
  bit exp_done, exp_err;
  int exp_ea;

  task automatic model(input int nacks, input int nfrom);
    int nl, s;
    bit fin, ok;
    exp_q.delete(); nl = nacks; s = 0; fin = 0;
    exp_done = 0; exp_err = 0; exp_ea = 0;
    for (int i = 0; i < NE && !fin; i++) begin
      if (rom_a[i] == 16'hFFFF) begin
        exp_done = 1; fin = 1;
      end else if (rom_a[i] != 16'hFFF0) begin
        ok = 0;
        for (int t = 0; t <= MAXR && !ok; t++) begin
          exp_q.push_back(rom_a[i]);
          ok = !(s >= nfrom && nl > 0);
          if (!ok) nl--;
          s++;
        end
        if (!ok) begin exp_err = 1; exp_ea = i; fin = 1; end
      end
    end
    if (!fin) begin exp_err = 1; exp_ea = NE - 1; end
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (o_busy && c < budget) begin @(negedge clk); c++; end
    if (o_busy) begin
      n_vec++; n_err++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, expected 0", o_busy, budget);
    end
  endtask

  task automatic wait_log(input int n, input int budget);
    int c = 0;
    while (log_q.size() < n && c < budget) begin @(negedge clk); c++; end
    if (log_q.size() < n) begin
      n_vec++; n_err++;
      $display("FAIL wait_log: %0d writes seen, expected %0d", log_q.size(), n);
    end
  endtask

  int t_start;
  task automatic pulse_start();
    @(negedge clk); cfg_start = 1'b1; t_start = cyc;
    @(negedge clk); cfg_start = 1'b0;
  endtask

  task automatic arm(input int nacks, input int nfrom);
    log_q.delete(); log_cyc.delete();
    nack_left = nacks; nack_from = nfrom; n_starts = 0;
  endtask

  task automatic run(input int nacks, input int nfrom, input int budget);
    arm(nacks, nfrom);
    pulse_start();
    wait_idle(budget);
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_nwr"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk({tag, "_wr"}, log_q[i], exp_q[i]);
    chk({tag, "_done"}, o_done, exp_done);
    chk({tag, "_err"}, o_err, exp_err);
    chk({tag, "_busy"}, o_busy, 1'b0);
    if (exp_err) chk({tag, "_eaddr"}, err_addr, exp_ea);
  endtask

  task automatic load_rom(input logic [15:0] e0, e1, e2, e3);
    for (int i = 0; i < NE; i++) rom_a[i] = 16'($urandom);
    rom_a[0] = e0; rom_a[1] = e1; rom_a[2] = e2; rom_a[3] = e3;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, o_busy, 1'b0);   chk({tag, "_done"}, o_done, 1'b0);
    chk({tag, "_err"}, o_err, 1'b0);     chk({tag, "_start"}, o_start, 1'b0);
    chk({tag, "_reg"}, o_reg, 8'h00);    chk({tag, "_data"}, o_data, 8'h00);
    chk({tag, "_romaddr"}, rom_addr, 4'h0); chk({tag, "_eaddr"}, err_addr, 4'h0);
    chk({tag, "_i2caddr"}, o_addr, 8'h42);
  endtask

  initial begin
    int gap;
    for (int i = 0; i < 4; i++) rom_b[i] = 24'hFFFFFF;
    load_rom(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Delay marker between two writes
    load_rom(16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF);
    model(0, 0);
    chk("model_t1_n", exp_q.size(), 2);
    run(0, 0, 20_000);
    check_run("t1");
    chk("t1_nwr_lit", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("t1_w0", log_q[0], 16'h1280);
      chk("t1_w1", log_q[1], 16'h1101);
      gap = log_cyc[1] - log_cyc[0];
      chk("t1_gap_min", gap >= DLYC, 1'b1);
      chk("t1_gap_max", gap <= DLYC + 60, 1'b1);
    end
    if (log_cyc.size() >= 1) chk("t1_latency", log_cyc[0] - t_start, 4);

    // Two NACKs on the second entry, recovered by retry
    load_rom(16'h1280, 16'h3A04, 16'hFFFF, 16'hFFFF);
    model(2, 1);
    chk("model_t2_n", exp_q.size(), 4);
    run(2, 1, 2000);
    check_run("t2");
    chk("t2_done_lit", o_done, 1'b1);

    // Four NACKs: retries exhausted on entry 1
    model(4, 1);
    chk("model_t3_ea", exp_ea, 1);
    run(4, 1, 2000);
    check_run("t3");
    chk("t3_eaddr_lit", err_addr, 4'h1);
    chk("t3_nwr_lit", log_q.size(), 5);

    // Ready never drops after start
    load_rom(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    stuck = 1'b1;
    run(0, 0, 3000);
    stuck = 1'b0;
    chk("t4_err", o_err, 1'b1);
    chk("t4_done", o_done, 1'b0);
    chk("t4_eaddr", err_addr, 4'h0);
    if (log_cyc.size() >= 1) begin
      gap = cyc - log_cyc[0];
      chk("t4_to_min", gap >= BTO, 1'b1);
      chk("t4_to_max", gap <= BTO + 2, 1'b1);
    end

    // 16-bit register field
    rom_b[0] = 24'h300A56;
    @(negedge clk); cfg_start_b = 1'b1;
    @(negedge clk); cfg_start_b = 1'b0;
    for (int c = 0; c < 200 && ob_busy; c++) @(negedge clk);
    chk("b_busy", ob_busy, 1'b0);
    chk("b_nwr", nb, 1);
    chk("b_reg", log_b[23:8], 16'h300A);
    chk("b_data", log_b[7:0], 8'h56);
    chk("b_done", ob_done, 1'b1);
    chk("b_err", ob_err, 1'b0);

    // No END marker anywhere: error at the last entry
    for (int i = 0; i < NE; i++) rom_a[i] = {8'($urandom_range(254, 0)), 8'($urandom)};
    model(0, 0);
    chk("model_t6_ea", exp_ea, NE - 1);
    run(0, 0, 3000);
    check_run("t6");

    // Randomized tables and NACK patterns
    for (int r = 0; r < 8; r++) begin
      int k, nk, nf;
      bit noend;
      k = $urandom_range(8, 1);
      noend = ($urandom_range(3, 0) == 0);
      for (int i = 0; i < NE; i++)
        rom_a[i] = (noend || i < k) ? {8'($urandom_range(254, 0)), 8'($urandom)}
                                    : ((i == k) ? 16'hFFFF : 16'($urandom));
      nk = $urandom_range(5, 0);
      nf = $urandom_range(3, 0);
      model(nk, nf);
      run(nk, nf, 4000);
      check_run("rnd");
    end

    // Restart while a transfer is in flight
    resp_min = 20; resp_max = 20;
    load_rom(16'h1280, 16'h3A04, 16'h1101, 16'hFFFF);
    model(0, 0);
    exp_q.push_front(16'h1280);
    arm(0, 0);
    pulse_start();
    wait_log(1, 50);
    repeat (4) @(negedge clk);
    chk("t8_in_xfer", rdy, 1'b0);
    pulse_start();
    wait_idle(1000);
    check_run("t8");
    if (log_cyc.size() >= 2) chk("t8_no_abort", (log_cyc[1] - log_cyc[0]) >= 20, 1'b1);
    resp_min = 1; resp_max = 5;

    // Async reset in the middle of a delay, then rerun
    load_rom(16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF);
    arm(0, 0);
    pulse_start();
    wait_log(1, 50);
    repeat (100) @(negedge clk);
    chk("t9_in_dly", o_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t9rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model(0, 0);
    run(0, 0, 20_000);
    check_run("t9");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
